// File: rtl/problema_lcd_button_pio.sv
// Debounced button PIO with edge capture, interrupt mask and Avalon-MM register access.
// Each channel: 2-flop synchronizer, stability counter, debounced level and sticky edge flag.
module problema_lcd_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  TC     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_V = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] upd, edge_set, clr;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // A counter only advances while sync disagrees with deb; any agreement restarts the window.
  always_comb begin
    deb_d = deb_q;
    upd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == TC) begin
          upd[i]   = 1'b1;
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = upd & sync_q;
      1:       edge_set = upd & ~sync_q;
      default: edge_set = upd;
    endcase
    clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_d  = (cap_q & ~clr) | edge_set;
    mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd1:    readdata_d[WIDTH-1:0] = sync_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q     <= IDLE_V;
      sync_q     <= IDLE_V;
      deb_q      <= IDLE_V;
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q     <= in_port;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/problema_lcd_button_pio.md
PROBLEMA_LCD_BUTTON_PIO -- requirements
Module: problema_lcd_button_pio

Interface
REQ-001 Parameter WIDTH, default 4: number of button input channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: required stable cycles before accepting a change, minimum 1.
REQ-003 Parameter EDGE_TYPE, default 1: captured edge; 0 rising, 1 falling, 2 any.
REQ-004 Parameter IDLE_LEVEL, default 1: inactive button level, applied to all channels.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select; qualifies write_n.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data; only bits [WIDTH-1:0] are used.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  WIDTH  raw asynchronous button inputs.
REQ-013 irq  output  1  level interrupt request, active-high.

Function
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-015 Each channel SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES+1), counting while sync differs from the debounced value (deb).
REQ-016 The counter SHALL clear to 0 whenever sync equals deb, so a glitch restarts the qualification window.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs from deb, deb SHALL take the sync value on the next edge and the counter SHALL clear.
REQ-018 Latency from a stable in_port change to deb SHALL be exactly 2+DEBOUNCE_CYCLES cycles; pulses shorter than DEBOUNCE_CYCLES cycles at sync SHALL never reach deb.
REQ-019 The edge-capture register (cap[WIDTH-1:0]) bit SHALL set on the same clock edge that deb changes in the direction selected by EDGE_TYPE.
REQ-020 Register map, address 0: read deb, bits above WIDTH-1 read 0; writes ignored.
REQ-021 Register map, address 1: read sync, the raw synchronized inputs; writes ignored.
REQ-022 Register map, address 2: read/write mask[WIDTH-1:0], the interrupt enable mask.
REQ-023 Register map, address 3: read cap; a write clears each cap bit whose writedata bit is 1 (write-1-to-clear).
REQ-024 A write SHALL occur only when chipselect=1 and write_n=0.
REQ-025 If a new edge and a clearing write hit the same cap bit in the same cycle, set SHALL win.
REQ-026 readdata SHALL update every clock from the address mux, zero-extended to 32 bits: one-cycle read latency, no read side effects.
REQ-027 irq SHALL be OR-reduce(cap & mask), driven combinationally from registers and held until cleared or masked.
REQ-028 A mask write SHALL affect irq in the cycle after the write edge; cap bits SHALL set regardless of mask.

Reset
REQ-029 While reset_n=0: sync and deb all IDLE_LEVEL; counters 0; cap 0; mask 0; readdata 0; irq 0.
REQ-030 Reset SHALL take effect asynchronously, including mid-debounce, discarding partial counts; release SHALL produce no cap bits when inputs sit at IDLE_LEVEL.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=1, IDLE_LEVEL=1)
REQ-031 in_port 4'hF->4'hE held -> deb reads 4'hE after exactly 6 cycles; cap=4'h1; irq stays 0 (mask 0).
REQ-032 in_port[1] pulsed low for 3 cycles -> deb unchanged at 4'hF; cap stays 0.
REQ-033 mask=4'h2, bit1 falls and is held -> irq rises with deb change; write 4'h2 to address 3 -> cap=0, irq=0 next cycle.
REQ-034 Clearing write to address 3 in the same cycle as a new bit0 falling edge -> cap[0]=1 afterwards.
REQ-035 reset_n asserted mid-count with in_port=4'h0, then released -> deb=4'hF, cap=0, readdata=0 during reset; deb=4'h0 reached 6 cycles after release, cap=4'hF.
REQ-036 Read address 0..3 back-to-back -> readdata returns deb, sync, mask, cap, each one cycle after its address.
